// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C request arbiter and the master it drives.
package i2c_pkg;

  localparam int ADDR_W  = 7;
  localparam int NBYTE_W = 5;
  localparam int TIMER_W = 12;
  localparam int RETRY_W = 4;

  // Master sequencer state encodings, IDLE through STOP.
  typedef enum logic [3:0] {
    MST_IDLE     = 4'd0,
    MST_START    = 4'd1,
    MST_ADDR     = 4'd2,
    MST_ADDR_ACK = 4'd3,
    MST_WR       = 4'd4,
    MST_WR_ACK   = 4'd5,
    MST_RD       = 4'd6,
    MST_RD_ACK   = 4'd7,
    MST_STOP     = 4'd8
  } i2c_mst_state_t;

  // Arbiter FSM states.
  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_ARB     = 3'd1,
    ARB_LAUNCH  = 3'd2,
    ARB_WAIT    = 3'd3,
    ARB_BACKOFF = 3'd4,
    ARB_DONE    = 3'd5
  } arb_state_t;

  // Command captured from the winning requester.
  typedef struct packed {
    logic               rw;
    logic [ADDR_W-1:0]  addr;
    logic [NBYTE_W-1:0] nbyte;
  } i2c_cmd_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set request at or
// after rr_ptr, wrapping from N_REQ-1 back to 0.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    rr_ptr,
  output logic [PW-1:0]    winner,
  output logic             valid
);

  // Scan N_REQ positions starting at rr_ptr; keep the first hit.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      int j;
      j = int'(rr_ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        winner = PW'(j);
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one I2C master between N_REQ clients: round-robin grant, command
// latch, launch, NACK retry with backoff, timeout, and done/err pulse.
//
// Handshakes:
//   client side : req is a level held until the granted client sees a
//                 one-cycle done or err pulse; the command is sampled once
//                 (in ARB) and the client must drop req for >= 1 clk after.
//   master side : m_ena is held high until m_busy is seen high (valid held
//                 until ready); completion is the one-cycle m_stop_done,
//                 qualified by the sticky m_nack.
module i2c_req_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 4095,
  parameter int BACKOFF   = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_rw,
  input  logic [ADDR_W*N_REQ-1:0]  req_addr,
  input  logic [NBYTE_W*N_REQ-1:0] req_nbyte,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic [N_REQ-1:0]         err,
  output logic                     m_ena,
  output logic                     m_rw,
  output logic [ADDR_W-1:0]        m_addr,
  output logic [NBYTE_W-1:0]       m_nbyte,
  input  logic                     m_busy,
  input  logic                     m_stop_done,
  input  logic                     m_nack,
  output arb_state_t               dbg_state
);

  localparam int PW = $clog2(N_REQ);
  localparam logic [TIMER_W-1:0] TIMEOUT_T = TIMER_W'(TIMEOUT);
  localparam logic [TIMER_W-1:0] BACKOFF_T = TIMER_W'(BACKOFF);
  localparam logic [RETRY_W-1:0] RETRY_T   = RETRY_W'(MAX_RETRY);

  arb_state_t         state_q, state_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TIMER_W-1:0] timer_inc;
  i2c_cmd_t           cmd_q, cmd_d;
  logic               is_err_q, is_err_d;
  logic [PW-1:0]      win_idx;
  logic               win_valid;
  i2c_cmd_t           win_cmd;

  rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .winner (win_idx),
    .valid  (win_valid)
  );

  // Command fields of the current round-robin winner.
  always_comb begin
    win_cmd.rw    = req_rw[win_idx];
    win_cmd.addr  = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
    win_cmd.nbyte = req_nbyte[int'(win_idx)*NBYTE_W +: NBYTE_W];
  end

  // The timer counts the current cycle; an expiry fires when the count of
  // elapsed cycles reaches the limit, so WAIT lasts exactly TIMEOUT clks.
  assign timer_inc = timer_q + 1'b1;

  // Next-state and next-datapath decisions.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    retry_d  = retry_q;
    timer_d  = timer_q;
    cmd_d    = cmd_q;
    is_err_d = is_err_q;
    case (state_q)
      ARB_IDLE: begin
        if (|req) state_d = ARB_ARB;
      end
      ARB_ARB: begin
        if (!win_valid) begin
          state_d = ARB_IDLE;
        end else begin
          owner_d = win_idx;
          cmd_d   = win_cmd;
          timer_d = '0;
          retry_d = '0;
          if (win_cmd.nbyte == '0) begin
            is_err_d = 1'b1;
            state_d  = ARB_DONE;
          end else begin
            is_err_d = 1'b0;
            state_d  = ARB_LAUNCH;
          end
        end
      end
      ARB_LAUNCH: begin
        if (m_busy) begin
          timer_d = '0;
          state_d = ARB_WAIT;
        end else if (timer_inc == TIMEOUT_T) begin
          is_err_d = 1'b1;
          state_d  = ARB_DONE;
        end else begin
          timer_d = timer_inc;
        end
      end
      ARB_WAIT: begin
        // stop_done is checked first so it wins over a same-cycle timeout.
        if (m_stop_done) begin
          if (!m_nack) begin
            is_err_d = 1'b0;
            state_d  = ARB_DONE;
          end else if (retry_q < RETRY_T) begin
            retry_d = retry_q + 1'b1;
            timer_d = '0;
            state_d = ARB_BACKOFF;
          end else begin
            is_err_d = 1'b1;
            state_d  = ARB_DONE;
          end
        end else if (timer_inc == TIMEOUT_T) begin
          is_err_d = 1'b1;
          state_d  = ARB_DONE;
        end else begin
          timer_d = timer_inc;
        end
      end
      ARB_BACKOFF: begin
        if (timer_inc >= BACKOFF_T) begin
          timer_d = '0;
          state_d = ARB_LAUNCH;
        end else begin
          timer_d = timer_inc;
        end
      end
      ARB_DONE: begin
        rr_ptr_d = (owner_q == PW'(N_REQ-1)) ? '0 : owner_q + 1'b1;
        retry_d  = '0;
        timer_d  = '0;
        state_d  = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers: owner, pointer, retry count, timer, latched command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= '0;
      rr_ptr_q <= '0;
      retry_q  <= '0;
      timer_q  <= '0;
      cmd_q    <= '0;
      is_err_q <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      retry_q  <= retry_d;
      timer_q  <= timer_d;
      cmd_q    <= cmd_d;
      is_err_q <= is_err_d;
    end
  end

  // Grant, launch and completion outputs decoded from the state.
  always_comb begin
    gnt   = '0;
    done  = '0;
    err   = '0;
    m_ena = (state_q == ARB_LAUNCH);
    if (state_q inside {ARB_LAUNCH, ARB_WAIT, ARB_BACKOFF, ARB_DONE})
      gnt[owner_q] = 1'b1;
    if (state_q == ARB_DONE) begin
      if (is_err_q) err[owner_q]  = 1'b1;
      else          done[owner_q] = 1'b1;
    end
  end

  assign m_rw      = cmd_q.rw;
  assign m_addr    = cmd_q.addr;
  assign m_nbyte   = cmd_q.nbyte;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Randomized scoreboard bench for i2c_req_arbiter with a behavioural
// I2C master and a transaction-level round-robin reference model.
module tb_i2c_req_arbiter;
  import i2c_pkg::*;

  localparam int N    = 4;
  localparam int MAXR = 3;
  localparam int TMO  = 200;
  localparam int BO   = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req, req_rw;
  logic [7*N-1:0]   req_addr;
  logic [5*N-1:0]   req_nbyte;
  logic [N-1:0]     gnt, done, err;
  logic             m_ena, m_rw;
  logic [6:0]       m_addr;
  logic [4:0]       m_nbyte;
  logic             m_busy, m_stop_done, m_nack;
  arb_state_t       dbg_state;

  i2c_req_arbiter #(.N_REQ(N), .MAX_RETRY(MAXR), .TIMEOUT(TMO), .BACKOFF(BO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_nbyte(req_nbyte), .gnt(gnt), .done(done), .err(err), .m_ena(m_ena),
    .m_rw(m_rw), .m_addr(m_addr), .m_nbyte(m_nbyte), .m_busy(m_busy),
    .m_stop_done(m_stop_done), .m_nack(m_nack), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  // exp_q entry: {launches[3:0], is_err, owner[2:0]}
  logic [7:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int model_ptr = 0;

  logic       c_rw[N];
  logic [6:0] c_addr[N];
  logic [4:0] c_nbyte[N];
  int         c_nack[N];
  bit         c_hang[N];
  int         c_delay[N];
  int         launch_cnt[N];

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic setup_client(input int i, input int rw, input int addr, input int nbyte,
                              input int nack, input bit hang, input int delay);
    c_rw[i] = 1'(rw); c_addr[i] = 7'(addr); c_nbyte[i] = 5'(nbyte);
    c_nack[i] = nack; c_hang[i] = hang; c_delay[i] = delay;
    req_rw[i] = 1'(rw);
    req_addr[7*i +: 7] = 7'(addr);
    req_nbyte[5*i +: 5] = 5'(nbyte);
  endtask

  task automatic random_client(input int i, input bit allow_hang);
    int nb, nk;
    nb = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 31));
    nk = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 4));
    setup_client(i, int'($urandom_range(0, 1)), int'($urandom_range(0, 127)), nb, nk,
                 allow_hang && ($urandom_range(0, 3) == 0), int'($urandom_range(3, 12)));
  endtask

  // Reference model: all requesters in mask are served once, in cyclic
  // order from the pointer; outcome follows from the client's plan.
  task automatic push_model(input logic [N-1:0] mask);
    int last, l;
    bit e;
    last = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (model_ptr + k) % N;
      if (mask[j]) begin
        if (c_nbyte[j] == 0)        begin l = 0;           e = 1'b1; end
        else if (c_hang[j])         begin l = 1;           e = 1'b1; end
        else if (c_nack[j] <= MAXR) begin l = c_nack[j]+1; e = 1'b0; end
        else                        begin l = MAXR + 1;    e = 1'b1; end
        exp_q.push_back({4'(l), e, 3'(j)});
        last = j;
      end
    end
    if (last >= 0) model_ptr = (last + 1) % N;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    req = '0;
    model_ptr = 0;
    for (int i = 0; i < N; i++) launch_cnt[i] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) @(negedge clk);
    check_eq("drain_pending", exp_q.size(), 0);
    if (exp_q.size() != 0) do_reset();
    repeat (3) @(negedge clk);
    check_eq("idle_gnt", int'(gnt), 0);
  endtask

  task automatic go(input logic [N-1:0] mask, input int budget);
    push_model(mask);
    req = req | mask;
    drain(budget);
  endtask

  // ---------------- behavioural I2C master ----------------
  initial begin
    int cur, att, t0, t_stop;
    bit bo_pend;
    m_busy = 1'b0; m_stop_done = 1'b0; m_nack = 1'b0;
    bo_pend = 1'b0; t_stop = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bo_pend = 1'b0; m_busy = 1'b0; m_stop_done = 1'b0; m_nack = 1'b0;
      end else if (m_ena && !m_busy) begin
        cur = (exp_q.size() != 0) ? int'(exp_q[0][2:0]) : 0;
        check_eq("launch_gnt", int'(gnt), 1 << cur);
        check_eq("launch_cmd", int'({m_rw, m_addr, m_nbyte}),
                 int'({c_rw[cur], c_addr[cur], c_nbyte[cur]}));
        if (bo_pend) check_eq("backoff_gap", cyc - t_stop, BO + 1);
        bo_pend = 1'b0;
        att = launch_cnt[cur];
        launch_cnt[cur]++;
        // Client inputs change after the grant; the latched command must hold.
        req_rw[cur] = 1'($urandom);
        req_addr[7*cur +: 7] = 7'($urandom);
        req_nbyte[5*cur +: 5] = 5'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        m_busy = 1'b1;
        t0 = cyc;
        if (c_hang[cur]) begin
          for (int k = 0; k < TMO + 20; k++) begin
            @(negedge clk);
            if (!rst_n || err[cur]) break;
          end
          if (rst_n) check_eq("timeout_gap", cyc - t0, TMO + 1);
          m_busy = 1'b0;
        end else begin
          repeat (c_delay[cur]) @(negedge clk);
          if (rst_n) begin
            m_stop_done = 1'b1;
            m_nack = (att < c_nack[cur]);
            t_stop = cyc;
            bo_pend = m_nack && (att < MAXR);
            @(negedge clk);
          end
          m_stop_done = 1'b0; m_nack = 1'b0; m_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor: pop and compare on every pulse ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && (|done || |err)) begin
        logic [7:0] e;
        int idx;
        check_eq("pulse_single", $countones(done | err) + ((|(done & err)) ? 8 : 0), 1);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_pulse", int'(done | err), 0);
        end else begin
          e = exp_q.pop_front();
          idx = int'(e[2:0]);
          check_eq("pulse_owner", int'(done | err), 1 << idx);
          check_eq("pulse_is_err", int'(|err), int'(e[3]));
          check_eq("pulse_gnt", int'(gnt), 1 << idx);
          check_eq("launch_count", launch_cnt[idx], int'(e[7:4]));
          launch_cnt[idx] = 0;
          req[idx] = 1'b0;
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- main stimulus ----------------
  initial begin
    int t;
    rst_n = 1'b0;
    req = '0; req_rw = '0; req_addr = '0; req_nbyte = '0;
    for (int i = 0; i < N; i++) begin
      launch_cnt[i] = 0;
      setup_client(i, 0, 0, 1, 0, 1'b0, 5);
    end
    repeat (3) @(negedge clk);
    check_eq("rst_gnt", int'(gnt), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_err", int'(err), 0);
    check_eq("rst_m_ena", int'(m_ena), 0);
    check_eq("rst_m_cmd", int'({m_rw, m_addr, m_nbyte}), 0);
    check_eq("rst_state", int'(dbg_state), int'(ARB_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Single request: client 1, write 0x50, 3 bytes, ack after 40 clks.
    setup_client(1, 0, 'h50, 3, 0, 1'b0, 40);
    push_model(4'b0010);
    req[1] = 1'b1;
    t = cyc;
    for (int k = 0; k < 10 && !m_ena; k++) @(negedge clk);
    check_eq("launch_latency", cyc - t, 2);
    drain(400);

    // Pointer now at 2: clients 0,1,3 must be served 3,0,1.
    for (int i = 0; i < N; i++) random_client(i, 1'b0);
    for (int i = 0; i < N; i++) c_nack[i] = 0;
    go(4'b1011, 3000);

    // NACK twice then ack; NACK every time; hang to timeout; nbyte zero.
    setup_client(2, 1, 'h3C, 7, 2, 1'b0, 6);
    go(4'b0100, 2000);
    setup_client(0, 0, 'h11, 2, 4, 1'b0, 5);
    go(4'b0001, 2000);
    setup_client(3, 1, 'h68, 9, 0, 1'b1, 5);
    go(4'b1000, 2000);
    setup_client(1, 0, 'h22, 0, 0, 1'b0, 5);
    go(4'b0010, 200);

    // Randomized mixes of requesters and master behaviour.
    for (int s = 0; s < 25; s++) begin
      logic [N-1:0] mask;
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) if (mask[i]) random_client(i, (s % 5) == 0);
      go(mask, 6000);
    end

    // Reset while a transfer sits in WAIT.
    setup_client(2, 1, 'h2A, 4, 0, 1'b1, 5);
    push_model(4'b0100);
    req[2] = 1'b1;
    for (int k = 0; k < 50 && !(m_busy && !m_ena && |gnt); k++) @(negedge clk);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_gnt", int'(gnt), 0);
    check_eq("midrst_m_ena", int'(m_ena), 0);
    check_eq("midrst_done_err", int'({done, err}), 0);
    exp_q.delete();
    model_ptr = 0;
    for (int i = 0; i < N; i++) begin
      launch_cnt[i] = 0;
      setup_client(i, int'($urandom_range(0, 1)), int'($urandom_range(0, 127)),
                   int'($urandom_range(1, 31)), 0, 1'b0, int'($urandom_range(3, 8)));
    end
    // All four pending across the release: served 0,1,2,3, then 0 again.
    push_model(4'b1111);
    req = 4'b1111;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drain(3000);
    setup_client(0, 0, 'h5A, 1, 0, 1'b0, 4);
    go(4'b0001, 500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
